stream_demux_1_4: RTL and testbench

Routes one valid/ready input stream to one of four output streams, the inverse direction of the team's 4:1 select muxes. Each input beat carries a 2-bit destination. Routing locks for the length of a multi-beat packet. Each output has a one-entry register slot, so outputs are registered, drain independently, and one stalled port never blocks beats bound for other ports.

---
 rtl/stream_demux_pkg.sv | 12 +
 rtl/demux_out_slot.sv | 53 +++++
 rtl/stream_demux_1_4.sv | 84 ++++++++
 tb/tb_stream_demux_1_4.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and route-FSM state type for the 1:4 stream demultiplexer.
package stream_demux_pkg;

   localparam int NUM_PORTS = 4;
   localparam int SEL_W     = 2;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } route_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice: holds a single beat until its consumer takes it.
module demux_out_slot #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             out_ready,
   output logic             can_accept,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;

   // A full slot can still take a beat when it drains in the same cycle.
   assign can_accept = ~valid_q | out_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
         last_d  = in_last;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// Routes one valid/ready stream to one of four registered output ports,
// holding the destination fixed for the duration of a multi-beat packet.
module stream_demux_1_4
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [SEL_W-1:0]           in_sel,
   input  logic                       in_last,
   output logic [NUM_PORTS-1:0]       out_valid,
   input  logic [NUM_PORTS-1:0]       out_ready,
   output logic [NUM_PORTS*WIDTH-1:0] out_data,
   output logic [NUM_PORTS-1:0]       out_last
);

   route_state_e         state_q, state_d;
   logic [SEL_W-1:0]     lock_sel_q, lock_sel_d;
   logic [SEL_W-1:0]     route;
   logic [NUM_PORTS-1:0] slot_ready;
   logic [NUM_PORTS-1:0] load;
   logic                 accept;

   // in_sel only steers the first beat; later beats follow the latched port.
   assign route    = (state_q == ST_LOCKED) ? lock_sel_q : in_sel;
   assign in_ready = slot_ready[route];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load        = '0;
      load[route] = accept;
   end

   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !in_last) begin
               state_d    = ST_LOCKED;
               lock_sel_d = in_sel;
            end
         end
         ST_LOCKED: begin
            if (accept && in_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
      demux_out_slot #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[k]),
         .in_data   (in_data),
         .in_last   (in_last),
         .out_ready (out_ready[k]),
         .can_accept(slot_ready[k]),
         .out_valid (out_valid[k]),
         .out_data  (out_data[k*WIDTH +: WIDTH]),
         .out_last  (out_last[k])
      );
   end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4: directed scenarios then a long random run.
module tb_stream_demux_1_4;

   localparam int WIDTH = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_data;
   logic [1:0]   in_sel;
   logic         in_last;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [15:0]  out_data;
   logic [3:0]   out_last;

   stream_demux_1_4 #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;

   // Per-port expected beats {last, data}, pushed on acceptance, popped on output transfer.
   logic [4:0] sbQ [4][$];

   // Reference model of the route FSM and slot occupancy.
   logic [3:0] mOcc    = '0;
   logic       mLocked = 1'b0;
   logic [1:0] mLock   = '0;

   logic [3:0] held = '0;
   logic [3:0] heldData [4];
   logic       heldLast [4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, checks in_ready and out_valid against the model,
   // then advances the model.  expRdy < 0 means take the model's in_ready.
   task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [3:0] d,
                                input logic l, input logic [3:0] r, input int expRdy,
                                input string name);
      logic [1:0] route;
      logic       mRdy;
      logic       acc;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      @(negedge clk);
      route = mLocked ? mLock : s;
      mRdy  = !mOcc[route] || r[route];
      checkOutput({name, " in_ready"}, {31'd0, in_ready},
                  (expRdy < 0) ? {31'd0, mRdy} : expRdy);
      checkOutput({name, " out_valid"}, {28'd0, out_valid}, {28'd0, mOcc});
      acc = v && mRdy;
      for (int k = 0; k < 4; k++) begin
         if (acc && route == 2'(k)) mOcc[k] = 1'b1;
         else if (mOcc[k] && r[k])   mOcc[k] = 1'b0;
      end
      if (acc) begin
         sbQ[route].push_back({l, d});
         if (!mLocked && !l) begin
            mLocked = 1'b1;
            mLock   = s;
         end else if (mLocked && l) begin
            mLocked = 1'b0;
         end
      end
   endtask

   // Monitor: pops and compares on every output transfer, and checks stalled beats hold still.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (held[k]) begin
               checkOutput($sformatf("port%0d stall stable", k),
                           {26'd0, out_valid[k], out_last[k], out_data[k*4 +: 4]},
                           {26'd0, 1'b1, heldLast[k], heldData[k]});
            end
            if (out_valid[k] && out_ready[k]) begin
               held[k] = 1'b0;
               if (sbQ[k].size() == 0) begin
                  checkOutput($sformatf("port%0d unexpected beat", k),
                              {27'd0, out_last[k], out_data[k*4 +: 4]}, 32'hFFFF_FFFF);
               end else begin
                  checkOutput($sformatf("port%0d beat", k),
                              {27'd0, out_last[k], out_data[k*4 +: 4]},
                              {27'd0, sbQ[k].pop_front()});
               end
            end else if (out_valid[k]) begin
               held[k]     = 1'b1;
               heldData[k] = out_data[k*4 +: 4];
               heldLast[k] = out_last[k];
            end else begin
               held[k] = 1'b0;
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = '0;

      @(negedge clk);
      checkOutput("reset out_valid", {28'd0, out_valid}, 32'd0);
      checkOutput("reset out_data", {16'd0, out_data}, 32'd0);
      checkOutput("reset out_last", {28'd0, out_last}, 32'd0);
      checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
      #1 rst_n = 1'b1;

      $display("[TB] single-beat packets to each port");
      applyStimulus(1, 2'd0, 4'hA, 1, 4'hF, 1, "single sel0");
      applyStimulus(1, 2'd1, 4'hB, 1, 4'hF, 1, "single sel1");
      applyStimulus(1, 2'd2, 4'hC, 1, 4'hF, 1, "single sel2");
      applyStimulus(1, 2'd3, 4'hD, 1, 4'hF, 1, "single sel3");
      applyStimulus(0, 2'd0, 4'h0, 0, 4'hF, 1, "single idle");

      $display("[TB] locked 3-beat packet to port 2");
      applyStimulus(1, 2'd2, 4'h1, 0, 4'hF, 1, "lock beat1");
      applyStimulus(1, 2'd0, 4'h2, 0, 4'hF, 1, "lock beat2");
      applyStimulus(1, 2'd1, 4'h3, 1, 4'hF, 1, "lock beat3");
      applyStimulus(1, 2'd0, 4'h9, 1, 4'hF, 1, "unlock check");

      $display("[TB] stalled port 1, other port still flows");
      applyStimulus(1, 2'd1, 4'h4, 1, 4'hD, 1, "stall fill");
      applyStimulus(1, 2'd1, 4'h6, 1, 4'hD, 0, "stall blocked");
      applyStimulus(1, 2'd3, 4'h8, 1, 4'hD, 1, "stall bypass");
      applyStimulus(0, 2'd0, 4'h0, 0, 4'hF, 1, "stall drain");

      $display("[TB] drain and refill in the same cycle");
      applyStimulus(1, 2'd0, 4'hE, 1, 4'hE, 1, "bubble fill");
      applyStimulus(1, 2'd0, 4'h3, 1, 4'hE, 0, "bubble blocked");
      applyStimulus(1, 2'd0, 4'h5, 1, 4'hF, 1, "bubble refill");
      applyStimulus(0, 2'd0, 4'h0, 0, 4'hF, 1, "bubble out");

      $display("[TB] reset in the middle of a packet");
      applyStimulus(1, 2'd2, 4'h1, 0, 4'hF, 1, "rst beat1");
      applyStimulus(1, 2'd2, 4'h2, 0, 4'hF, 1, "rst beat2");
      #2;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      for (int k = 0; k < 4; k++) sbQ[k].delete();
      mOcc    = '0;
      mLocked = 1'b0;
      mLock   = '0;
      #1;
      checkOutput("async reset out_valid", {28'd0, out_valid}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1, 2'd1, 4'h7, 1, 4'hF, 1, "post-reset sel1");
      applyStimulus(0, 2'd0, 4'h0, 0, 4'hF, 1, "post-reset out");

      $display("[TB] random traffic");
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                       4'($urandom_range(0, 15)), -1, "random");
      end

      for (int i = 0; i < 3; i++) applyStimulus(0, 2'd0, 4'h0, 0, 4'hF, 1, "final drain");
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("port%0d leftover beats", k), sbQ[k].size(), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
